// File: rtl/conv_enc_framer.sv
// conv_enc_framer: rate-1/2 K=3 convolutional encoder that builds zero-tailed frames
// from a valid/ready bit stream and emits one coded bit per clock with frame strobes.
module conv_enc_framer #(
    parameter int         FRAME_BITS = 7,
    parameter int         TAIL_BITS  = 2,
    parameter logic [2:0] G0         = 3'b111,
    parameter logic [2:0] G1         = 3'b101
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic dout,
    output logic dout_valid,
    output logic frm_start,
    output logic frm_end,
    output logic busy
);
    localparam int P  = FRAME_BITS - TAIL_BITS;
    localparam int BW = $clog2(2 * FRAME_BITS);
    localparam int CW = $clog2(P + 1);

    typedef enum logic {IDLE, ENC} state_t;

    state_t          state_q, state_d;
    logic [P-1:0]    col_q, col_d, act_q, act_d, col_acc;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_acc;
    logic [BW-1:0]   bit_q, bit_d;
    logic [1:0]      enc_q, enc_d;
    logic            dout_q, dout_d, dv_q, dv_d, fs_q, fs_d, fe_q, fe_d;
    logic [FRAME_BITS-1:0] info;
    logic [2:0]      v;
    logic            accept, eof, load, u, code;

    assign din_ready  = cnt_q < CW'(P);
    assign busy       = state_q == ENC;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign frm_start  = fs_q;
    assign frm_end    = fe_q;

    always_comb begin
        accept  = din_valid & din_ready;
        col_acc = accept ? {din, col_q[P-1:1]} : col_q;
        cnt_acc = cnt_q + CW'(accept);
        eof     = bit_q == BW'(2 * FRAME_BITS - 1);
        // a bit accepted on the reload edge may complete the next frame
        load    = (cnt_acc == CW'(P)) && (state_q == IDLE || eof);
        info    = {{TAIL_BITS{1'b0}}, act_q};
        u       = info[bit_q[BW-1:1]];
        v       = {u, enc_q};
        code    = bit_q[0] ? ^(v & G1) : ^(v & G0);
        state_d = state_q;
        col_d   = col_acc;
        cnt_d   = cnt_acc;
        act_d   = act_q;
        bit_d   = bit_q;
        enc_d   = enc_q;
        dout_d  = 1'b0;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
        fe_d    = 1'b0;
        if (state_q == ENC) begin
            dout_d  = code;
            dv_d    = 1'b1;
            fs_d    = bit_q == '0;
            fe_d    = eof;
            enc_d   = bit_q[0] ? {u, enc_q[1]} : enc_q;
            bit_d   = eof ? '0 : bit_q + 1'b1;
            state_d = eof ? IDLE : ENC;
        end
        if (load) begin
            act_d   = col_acc;
            cnt_d   = '0;
            enc_d   = '0;
            bit_d   = '0;
            state_d = ENC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            cnt_q   <= '0;
            act_q   <= '0;
            bit_q   <= '0;
            enc_q   <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            bit_q   <= bit_d;
            enc_q   <= enc_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
        end
    end
endmodule

// File: tb/tb_conv_enc_framer.sv
// tb_conv_enc_framer: scoreboard bench for conv_enc_framer; expected coded bits
// are queued when a payload is driven and popped as valid coded bits appear.
module tb_conv_enc_framer;
    logic clk = 1'b0, reset = 1'b1, din = 1'b0, din_valid = 1'b0;
    logic din_ready, dout, dout_valid, frm_start, frm_end, busy;
    int n_pass = 0, n_chk = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_e;

    conv_enc_framer dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .frm_start(frm_start), .frm_end(frm_end), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // scoreboard monitor: entries are {dout, frm_start, frm_end}
    always @(negedge clk) begin
        if (!reset && dout_valid) begin
            n_chk++;
            if (exp_q.size() == 0)
                $display("FAIL unexpected_valid: dout=%b while no coded bit expected", dout);
            else begin
                mon_e = exp_q.pop_front();
                if ({dout, frm_start, frm_end} !== mon_e)
                    $display("FAIL coded_bit: got {dout,start,end}=%b expected %b", {dout, frm_start, frm_end}, mon_e);
                else
                    n_pass++;
            end
        end
    end

    // reference encoder: p[0] is the first payload bit, s[1] the most recent state bit
    task automatic push_frame(input logic [4:0] p);
        logic [1:0] s = 2'b00;
        logic u;
        for (int i = 0; i < 7; i++) begin
            u = (i < 5) ? p[i] : 1'b0;
            exp_q.push_back({u ^ s[1] ^ s[0], i == 0, 1'b0});
            exp_q.push_back({u ^ s[0], 1'b0, i == 6});
            s = {u, s[1]};
        end
    endtask

    // called at a negedge; returns at the negedge following the transfer edge
    task automatic send_bit(input logic b);
        int t = 0;
        din = b;
        din_valid = 1'b1;
        while (!din_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            $display("FAIL send_timeout: din_ready stayed %b for %0d cycles", din_ready, t);
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [4:0] p, input int gap);
        for (int i = 0; i < 5; i++) begin
            send_bit(p[i]);
            if (i < 4) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_drain(output bit ok);
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = exp_q.size() == 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int nv = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({dout, dout_valid, frm_start, frm_end, busy, din_ready} !== 6'b000001)
            $display("FAIL reset_values: got {dout,dv,fs,fe,busy,rdy}=%b expected 000001",
                     {dout, dout_valid, frm_start, frm_end, busy, din_ready});
        else n_pass++;
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            nv += int'(dout_valid);
        end
        n_chk++;
        if (nv !== 0) $display("FAIL idle_after_reset: %0d valid cycles expected 0", nv);
        else n_pass++;
    endtask

    task automatic test_single_frame(input int gap);
        logic [13:0] got;
        bit ok;
        push_frame(5'b01101);
        send_frame(5'b01101, gap);
        n_chk++;
        if (dout_valid !== 1'b0) $display("FAIL latency_early gap=%0d: dout_valid=%b expected 0", gap, dout_valid);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({dout_valid, frm_start, busy} !== 3'b111)
            $display("FAIL latency_first gap=%0d: {dv,fs,busy}=%b expected 111", gap, {dout_valid, frm_start, busy});
        else n_pass++;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            got[13-k] = dout;
        end
        n_chk++;
        if (got !== 14'b11100001011100)
            $display("FAIL known_answer gap=%0d: got %b expected 11100001011100", gap, got);
        else n_pass++;
        wait_drain(ok);
        n_chk++;
        if (!ok || dout_valid !== 1'b0)
            $display("FAIL single_drain gap=%0d: pending=%0d dout_valid=%b expected 0/0", gap, exp_q.size(), dout_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int run = 0, t = 0;
        int starts[$];
        push_frame(5'b01101);
        push_frame(5'b00000);
        push_frame(5'b11111);
        fork
            begin
                send_frame(5'b01101, 0);
                send_frame(5'b00000, 0);
                send_frame(5'b11111, 0);
            end
            begin
                while (!dout_valid && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                while (dout_valid && run < 100) begin
                    if (frm_start) starts.push_back(run);
                    run++;
                    @(negedge clk);
                end
            end
        join
        n_chk++;
        if (run !== 42) $display("FAIL b2b_contiguous: %0d valid clocks expected 42", run);
        else n_pass++;
        n_chk++;
        if (starts.size() != 3 || starts[0] != 0 || starts[1] != 14 || starts[2] != 28)
            $display("FAIL b2b_starts: %0d starts, first three %p expected 0,14,28", starts.size(), starts);
        else n_pass++;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL b2b_drain: %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int lows = 0;
        bit ok;
        push_frame(5'b10011);
        push_frame(5'b01010);
        push_frame(5'b11001);
        send_frame(5'b10011, 0);
        send_frame(5'b01010, 0);
        din = 1'b1;
        din_valid = 1'b1;
        n_chk++;
        if (din_ready !== 1'b0) $display("FAIL bp_ready_fall: din_ready=%b expected 0", din_ready);
        else n_pass++;
        while (!din_ready && lows < 100) begin
            lows++;
            @(negedge clk);
        end
        n_chk++;
        if (lows !== 9) $display("FAIL bp_ready_low: low for %0d cycles expected 9", lows);
        else n_pass++;
        send_frame(5'b11001, 0);
        wait_drain(ok);
        n_chk++;
        if (!ok || dout_valid !== 1'b0)
            $display("FAIL bp_drain: pending=%0d dout_valid=%b expected 0/0", exp_q.size(), dout_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int nv = 0;
        bit ok;
        push_frame(5'b01101);
        push_frame(5'b10101);
        send_frame(5'b01101, 0);
        fork
            send_frame(5'b10101, 0);
            repeat (6) @(negedge clk);
        join
        n_chk++;
        if (dout_valid !== 1'b1) $display("FAIL mid_frame_active: dout_valid=%b expected 1", dout_valid);
        else n_pass++;
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        n_chk++;
        if ({dout_valid, frm_start, din_ready, busy} !== 4'b0010)
            $display("FAIL async_reset: {dv,fs,rdy,busy}=%b expected 0010", {dout_valid, frm_start, din_ready, busy});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) begin
            @(negedge clk);
            nv += int'(dout_valid);
        end
        n_chk++;
        if (nv !== 0) $display("FAIL post_reset_quiet: %0d valid cycles expected 0", nv);
        else n_pass++;
        push_frame(5'b11111);
        send_frame(5'b11111, 0);
        wait_drain(ok);
        n_chk++;
        if (!ok || dout_valid !== 1'b0)
            $display("FAIL post_reset_frame: pending=%0d dout_valid=%b expected 0/0", exp_q.size(), dout_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame(0);
        test_single_frame(2);
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_enc_framer.md
Name: conv_enc_framer

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder with frame builder.
- Sits directly upstream of the frame-based Viterbi decoder.
- Accepts payload bits through a valid/ready handshake and appends zero tail bits so every frame ends in state 00.
- Emits a continuous serial coded-bit stream, one coded bit per clock, with frame-boundary strobes the decoder's 14-clock frame counter can align to.

Parameters:
- FRAME_BITS, 7: info bits per frame, tail included; coded frame length is 2*FRAME_BITS clocks.
- TAIL_BITS, 2: trailing zero info bits per frame; must equal K-1 = 2.
- G0, 3'b111: generator of the first coded bit of each pair; bit2 taps the current input, bit0 taps the oldest state bit.
- G1, 3'b101: generator of the second coded bit of each pair.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- din, input, 1: payload bit.
- din_valid, input, 1: din is valid this cycle.
- din_ready, output, 1: block accepts din this cycle; transfer when din_valid & din_ready at the rising edge.
- dout, output, 1: serial coded bit.
- dout_valid, output, 1: dout carries a coded bit.
- frm_start, output, 1: high with the first coded bit of a frame.
- frm_end, output, 1: high with the last (2*FRAME_BITS-th) coded bit of a frame.
- busy, output, 1: FSM in ENC.

Behaviour:
- Reset (async, active-high) values:
  - Outputs: dout=0, dout_valid=0, frm_start=0, frm_end=0, busy=0, din_ready=1.
  - Internals: collect buffer empty, encoder state 00, FSM IDLE.
- P = FRAME_BITS-TAIL_BITS = 5 payload bits per frame.
- Collect buffer:
  - P-bit shift register plus count; the first accepted bit is the first bit encoded.
  - din_ready = (count < P), registered-free combinational from count.
  - A transfer when count = P is impossible because ready is low.
- Active buffer: holds the frame currently being encoded.
- FSM states IDLE and ENC. Internal counters are bitcnt (0..2*FRAME_BITS-1) and phase (bitcnt[0]).
- IDLE:
  - dout_valid=0, dout=0.
  - When count = P at a rising edge: move collect to active, clear count, state <= 00, go to ENC, bitcnt <= 0.
  - The first coded bit is therefore registered on the edge after the last payload bit was accepted, i.e. one-cycle latency.
- ENC, per cycle:
  - Info bit u = active payload bit bitcnt/2 when bitcnt/2 < P, else 0 (tail).
  - Vector v = {u, s1, s0}, where s1 is the most recent state bit.
  - dout <= ^(v & G0) when phase=0, ^(v & G1) when phase=1.
  - On phase=1: {s1,s0} <= {u,s1}.
  - dout_valid <= 1; frm_start <= (bitcnt==0); frm_end <= (bitcnt==2*FRAME_BITS-1).
- End of frame (bitcnt = 2*FRAME_BITS-1):
  - If count = P at that same edge, including a final bit accepted at that edge: reload active, clear count, state 00, bitcnt <= 0, stay in ENC. The next frame follows with no bubble, so frm_start repeats every 2*FRAME_BITS clocks.
  - Otherwise go to IDLE; dout_valid drops on the next cycle.
- Simultaneous collect and reload on one edge: a bit accepted on the reload edge belongs to the reloaded frame if it completes P. Otherwise it remains in collect, and count continues from its new value.
- The collect buffer keeps accepting during ENC (double buffering).
- Encoder state is forced to 00 at each frame start, independent of the tail.
- Reset mid-frame: the frame is abandoned, buffers are cleared, and outputs return to reset values immediately. No partial frame is emitted after reset release.
- Width rule: bitcnt is clog2(2*FRAME_BITS) bits.
- Boundary: din_valid may toggle arbitrarily; gaps only delay frame assembly.

Test Plan:
- Reset → check values: assert reset mid-run → dout_valid=0, frm_start=0, din_ready=1 asynchronously; after release with no input, dout_valid stays 0.
- Single frame: payload 1,0,1,1,0 with din_valid held → one cycle after the 5th accept, dout over 14 clocks = 1,1,1,0,0,0,0,1,0,1,1,1,0,0. frm_start on bit 1, frm_end on bit 14, then dout_valid=0.
- Back-to-back: 3 frames supplied early (1,0,1,1,0 / 0,0,0,0,0 / 1,1,1,1,1) → contiguous 42 valid clocks.
  - frm_start at clocks 0, 14 and 28.
  - Frame 2 is all 0.
  - Frame 3 = 11 01 10 10 10 01 11.
- Backpressure: keep din_valid high during the first frame's encode → din_ready falls after 5 more accepts and stays low until the reload edge, then rises.
- Sparse input: din_valid pulsed every 3rd cycle with payload 1,0,1,1,0 → the output is identical to the single-frame sequence, starting one cycle after the 5th accept.
- Reset mid-frame: reset at coded bit 6 of a frame with the next frame already collected → no further valid bits. A fresh payload after release encodes correctly, with state starting at 00.
